core_run_ctrl: RTL

//  Run/halt/single-step controller for the pipelined core on the FPGA board.
//  It replaces the ripple clock divider with a single-clock scheme: it generates a core clock-enable
//  and a held core reset, driven by debounced KEY buttons.
//  It also provides a PC-match breakpoint and cycle/instruction counters for the HEX/LEDR debug view.

---
 rtl/core_ctrl_pkg.sv | 21 ++
 rtl/core_run_ctrl_if.sv | 44 ++++
 rtl/core_run_ctrl_btn_debounce.sv | 56 +++++
 rtl/core_run_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared types and constants for the core run/halt/step controller
package core_ctrl_pkg;

  // Width of the debug cycle and instruction counters
  localparam int CNT_W = 32;

  // Controller states; the encoding is visible on state_o
  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_HALT = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_BRK  = 3'd4
  } ctrl_state_e;

  // The core is considered stopped in both the manual halt and the breakpoint state
  function automatic logic is_halted(input ctrl_state_e s);
    return (s == S_HALT) || (s == S_BRK);
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// rtl/core_run_ctrl_if.sv - board-side buttons, core debug inputs and controller outputs
interface core_run_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  import core_ctrl_pkg::*;

  // Raw KEY inputs, active-low, asynchronous to clk_i
  logic                run_btn_i;
  logic                step_btn_i;
  logic                halt_btn_i;

  // Breakpoint setup and core debug view
  logic                bp_en_i;
  logic [PC_WIDTH-1:0] bp_addr_i;
  logic [PC_WIDTH-1:0] pc_i;
  logic                insn_vld_i;

  // Core control and debug outputs
  logic                core_clk_en_o;
  logic                core_rst_no;
  logic [2:0]          state_o;
  logic                halted_o;
  logic [CNT_W-1:0]    cycle_cnt_o;
  logic [CNT_W-1:0]    insn_cnt_o;
  // Debounced KEY levels {halt, step, run} for the LEDR view, 1 = released
  logic [2:0]          btn_level_o;

  // Controller side
  modport slave (
    input  run_btn_i, step_btn_i, halt_btn_i,
    input  bp_en_i, bp_addr_i, pc_i, insn_vld_i,
    output core_clk_en_o, core_rst_no, state_o, halted_o,
    output cycle_cnt_o, insn_cnt_o, btn_level_o
  );

  // Board / core side
  modport master (
    output run_btn_i, step_btn_i, halt_btn_i,
    output bp_en_i, bp_addr_i, pc_i, insn_vld_i,
    input  core_clk_en_o, core_rst_no, state_o, halted_o,
    input  cycle_cnt_o, insn_cnt_o, btn_level_o
  );

endinterface

// File: rtl/core_run_ctrl_btn_debounce.sv
// rtl/core_run_ctrl_btn_debounce.sv - two-flop synchroniser plus stable-count debounce for one KEY
module btn_debounce
  import core_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic press_o,
  output logic level_o
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);

  logic              sync1_q;
  logic              sync2_q;
  logic              level_q;
  logic              press_q;
  logic [DCNT_W-1:0] cnt_q;

  // Bring the asynchronous KEY into the clock domain; idle level is released (1)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DEBOUNCE_CYC consecutive differing samples; a press pulses on 1->0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync2_q == level_q) begin
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else if (cnt_q == DCNT_LAST) begin
      level_q <= sync2_q;
      press_q <= ~sync2_q;
      cnt_q   <= '0;
    end else begin
      press_q <= 1'b0;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign press_o = press_q;
  assign level_o = level_q;

endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run/halt/single-step controller producing the core clock enable and held reset
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int CLK_EN_DIV   = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int RST_HOLD_CYC = 8,
  parameter int PC_WIDTH     = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  core_run_ctrl_if.slave bus
);

  localparam int DIV_W  = (CLK_EN_DIV > 1) ? $clog2(CLK_EN_DIV) : 1;
  localparam int HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_EN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);

  ctrl_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              en_q, en_d;
  logic              core_rst_q, core_rst_d;
  logic              skip_q, skip_d;
  logic              halted_q;
  logic [CNT_W-1:0]  cycle_cnt_q;
  logic [CNT_W-1:0]  insn_cnt_q;

  logic              run_ev, step_ev, halt_ev;
  logic              run_lvl, step_lvl, halt_lvl;
  logic              pc_match;
  logic              bp_hit;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_db (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_ni  (bus.run_btn_i),
    .press_o (run_ev),
    .level_o (run_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_db (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_ni  (bus.step_btn_i),
    .press_o (step_ev),
    .level_o (step_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_halt_db (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_ni  (bus.halt_btn_i),
    .press_o (halt_ev),
    .level_o (halt_lvl)
  );

  // The PC is only trusted between enables: on a pulse cycle the core has not yet advanced
  assign pc_match = (bus.pc_i[PC_WIDTH-1:0] == bus.bp_addr_i[PC_WIDTH-1:0]);
  assign bp_hit   = bus.bp_en_i & bus.insn_vld_i & pc_match & ~skip_q & ~en_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, enable pulse, divider, reset hold and breakpoint skip
  always_comb begin
    state_d    = state_q;
    en_d       = 1'b0;
    div_d      = div_q;
    hold_d     = hold_q;
    core_rst_d = core_rst_q;
    skip_d     = skip_q;

    // A resumed breakpoint is passed once: the skip ends with the first enable after it was set
    if (en_q) begin
      skip_d = 1'b0;
    end

    unique case (state_q)
      S_RST: begin
        if (hold_q == HOLD_LAST) begin
          core_rst_d = 1'b1;
          state_d    = S_HALT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_HALT: begin
        if (run_ev) begin
          state_d = S_RUN;
          div_d   = '0;
        end else if (step_ev) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        // Halt beats breakpoint beats continuing; either one swallows a pulse due this cycle
        if (halt_ev) begin
          state_d = S_HALT;
        end else if (bp_hit) begin
          state_d = S_BRK;
        end else if (div_q == DIV_LAST) begin
          en_d  = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_STEP: begin
        en_d    = 1'b1;
        state_d = S_HALT;
      end
      S_BRK: begin
        if (run_ev) begin
          state_d = S_RUN;
          div_d   = '0;
          skip_d  = 1'b1;
        end else if (step_ev) begin
          state_d = S_STEP;
          skip_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q       <= 1'b0;
      div_q      <= '0;
      hold_q     <= '0;
      core_rst_q <= 1'b0;
      skip_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      en_q       <= en_d;
      div_q      <= div_d;
      hold_q     <= hold_d;
      core_rst_q <= core_rst_d;
      skip_q     <= skip_d;
      halted_q   <= is_halted(state_d);
    end
  end

  // Count each enable pulse, and those that carried a valid instruction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
      insn_cnt_q  <= '0;
    end else if (en_q) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (bus.insn_vld_i) begin
        insn_cnt_q <= insn_cnt_q + 1'b1;
      end
    end
  end

  assign bus.core_clk_en_o = en_q;
  assign bus.core_rst_no   = core_rst_q;
  assign bus.state_o       = state_q;
  assign bus.halted_o      = halted_q;
  assign bus.cycle_cnt_o   = cycle_cnt_q;
  assign bus.insn_cnt_o    = insn_cnt_q;
  assign bus.btn_level_o   = {halt_lvl, step_lvl, run_lvl};

endmodule
